ws2812_chain_driver: RTL and testbench

//  Parametrised WS2812 serial driver for an LED chain of NUM_LEDS pixels.

---
 rtl/ws2812_chain_driver.sv | 147 ++++++++++++++
 tb/tb_ws2812_chain_driver.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_chain_driver.sv
// WS2812 serial driver for a chain of NUM_LEDS pixels: write-port pixel buffer,
// global brightness scaling, and a start/busy/done frame handshake.
module ws2812_chain_driver #(
    parameter  int unsigned NUM_LEDS = 7,
    parameter  int unsigned T0H_CYC  = 4,
    parameter  int unsigned T1H_CYC  = 8,
    parameter  int unsigned TBIT_CYC = 15,
    parameter  int unsigned TRST_CYC = 960,
    localparam int unsigned ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_rgb,
    input  logic [7:0]        bright,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ws
);

    localparam int unsigned CYC_W = $clog2(TBIT_CYC + 1);
    localparam int unsigned LAT_W = $clog2(TRST_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BIT,
        ST_LATCH
    } state_t;

    state_t             state, state_n;
    logic [23:0]        pix_buf [NUM_LEDS];
    logic [23:0]        sh;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [4:0]         bit_cnt;
    logic [ADDR_W-1:0]  pix_cnt;
    logic [LAT_W-1:0]   lat_cnt;

    logic               cyc_last, bit_last, pix_last, lat_last;
    logic [CYC_W-1:0]   thigh;
    logic [ADDR_W-1:0]  fetch_idx;
    logic [23:0]        fetch_pix;
    logic [23:0]        fetch_word;

    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(c) * (16'(b) + 16'd1);
        return p[15:8];
    endfunction

    assign cyc_last = (cyc_cnt == CYC_W'(TBIT_CYC - 1));
    assign bit_last = (bit_cnt == 5'd23);
    assign pix_last = (pix_cnt == ADDR_W'(NUM_LEDS - 1));
    assign lat_last = (lat_cnt == LAT_W'(TRST_CYC - 1));
    assign thigh    = sh[23] ? CYC_W'(T1H_CYC) : CYC_W'(T0H_CYC);

    // Fetch index is pixel 0 in LOAD, otherwise the pixel following the one on the wire
    assign fetch_idx  = (state == ST_BIT && !pix_last) ? pix_cnt + ADDR_W'(1) : '0;
    assign fetch_pix  = pix_buf[fetch_idx];
    assign fetch_word = {scale8(fetch_pix[15:8],  bright),
                         scale8(fetch_pix[23:16], bright),
                         scale8(fetch_pix[7:0],   bright)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b1;
        ws      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_n = ST_LOAD;
            end
            ST_LOAD: state_n = ST_BIT;
            ST_BIT: begin
                ws = (cyc_cnt < thigh);
                if (cyc_last && bit_last && pix_last) state_n = ST_LATCH;
            end
            ST_LATCH: begin
                if (lat_last) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) pix_buf[i] <= '0;
        end else if (wr_en && (32'(wr_addr) < NUM_LEDS)) begin
            pix_buf[wr_addr] <= wr_rgb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh      <= '0;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            pix_cnt <= '0;
            lat_cnt <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == ST_LATCH) && lat_last;
            case (state)
                ST_LOAD: begin
                    sh      <= fetch_word;
                    cyc_cnt <= '0;
                    bit_cnt <= '0;
                    pix_cnt <= '0;
                end
                ST_BIT: begin
                    if (!cyc_last) begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end else begin
                        cyc_cnt <= '0;
                        if (!bit_last) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            sh      <= {sh[22:0], 1'b0};
                        end else begin
                            bit_cnt <= '0;
                            if (!pix_last) begin
                                pix_cnt <= pix_cnt + ADDR_W'(1);
                                sh      <= fetch_word;
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    lat_cnt <= lat_last ? '0 : lat_cnt + LAT_W'(1);
                end
                default: begin
                    cyc_cnt <= '0;
                    bit_cnt <= '0;
                    pix_cnt <= '0;
                    lat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Directed bench for ws2812_chain_driver: decodes ws pulse widths back into
// pixel words and checks frame timing and handshake against hand-computed values.
module tb_ws2812_chain_driver;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [23:0] wr_rgb;
    logic [7:0]  bright;
    logic        start;
    logic        busy;
    logic        done;
    logic        ws;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [23:0] pix [7];
    int          shape_err;
    int          latch_len;
    int          latch_bad;
    bit          cap_timeout;

    ws2812_chain_driver #(
        .NUM_LEDS (7),
        .T0H_CYC  (4),
        .T1H_CYC  (8),
        .TBIT_CYC (15),
        .TRST_CYC (960)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_rgb  (wr_rgb),
        .bright  (bright),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .ws      (ws)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_pix(input logic [2:0] a, input logic [23:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_rgb = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Leaves the bench at the negedge right after start was sampled (LOAD cycle)
    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Decodes one full frame from ws; returns at the negedge where done is seen
    task automatic capture();
        int n;
        int highs;
        cap_timeout = 0; shape_err = 0; latch_len = 0; latch_bad = 0;
        for (int p = 0; p < 7; p++) pix[p] = '0;
        n = 0;
        while (ws !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            cap_timeout = 1;
            return;
        end
        for (int p = 0; p < 7; p++) begin
            for (int b = 0; b < 24; b++) begin
                highs = 0;
                for (int c = 0; c < 15; c++) begin
                    if (ws === 1'b1) begin
                        if (c != highs) shape_err++;
                        highs++;
                    end
                    @(negedge clk);
                end
                if (highs != 8 && highs != 4) shape_err++;
                pix[p] = {pix[p][22:0], (highs == 8)};
            end
        end
        while (done !== 1'b1 && latch_len < 2000) begin
            if (ws !== 1'b0 || busy !== 1'b1) latch_bad++;
            latch_len++;
            @(negedge clk);
        end
        if (latch_len >= 2000) cap_timeout = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_rgb = '0; bright = 8'd255; start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ws, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: ws/busy/done=%b required 000", {ws, busy, done});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ws, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_outputs: ws/busy/done=%b required 000", {ws, busy, done});
        end
    endtask

    task automatic test_single_bit();
        bright = 8'd255;
        write_pix(3'd0, 24'h800000);
        kick();
        capture();
        n_checks++;
        if (cap_timeout || shape_err != 0) begin
            n_fail++;
            $display("FAIL bit_shapes: timeout=%0d shape_err=%0d required 0/0", cap_timeout, shape_err);
        end
        n_checks++;
        if (pix[0] !== 24'h008000) begin
            n_fail++;
            $display("FAIL led0_word: got %h required 008000", pix[0]);
        end
        for (int p = 1; p < 7; p++) begin
            n_checks++;
            if (pix[p] !== 24'h000000) begin
                n_fail++;
                $display("FAIL ledN_zero: led%0d got %h required 000000", p, pix[p]);
            end
        end
        n_checks++;
        if (latch_len != 960 || latch_bad != 0) begin
            n_fail++;
            $display("FAIL latch_gap: len=%0d bad=%0d required 960/0", latch_len, latch_bad);
        end
    endtask

    task automatic test_brightness();
        bright = 8'd127;
        write_pix(3'd3, 24'hFF8040);
        kick();
        capture();
        // 0x80*128>>8=0x40, 0xFF*128>>8=0x7F, 0x40*128>>8=0x20
        n_checks++;
        if (cap_timeout || pix[3] !== 24'h407F20) begin
            n_fail++;
            $display("FAIL led3_scaled: got %h required 407f20", pix[3]);
        end
        n_checks++;
        if (pix[0] !== 24'h004000) begin
            n_fail++;
            $display("FAIL led0_scaled: got %h required 004000", pix[0]);
        end
        bright = 8'd0;
        write_pix(3'd5, 24'hFFFFFF);
        kick();
        capture();
        n_checks++;
        if (cap_timeout || pix[5] !== 24'h000000 || pix[3] !== 24'h000000) begin
            n_fail++;
            $display("FAIL bright_zero: led5=%h led3=%h required 000000", pix[5], pix[3]);
        end
        bright = 8'd255;
        write_pix(3'd5, 24'h000000);
    endtask

    task automatic test_frame_timing();
        int cnt;
        int first_ws;
        int low_run;
        int busy_bad;
        kick();
        cnt = 0; first_ws = -1; low_run = 0; busy_bad = 0;
        while (done !== 1'b1 && cnt < 4000) begin
            if (busy !== 1'b1) busy_bad++;
            if (ws === 1'b1) begin
                if (first_ws < 0) first_ws = cnt;
                low_run = 0;
            end else begin
                low_run++;
            end
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (cnt != 3481) begin
            n_fail++;
            $display("FAIL frame_length: %0d cycles required 3481", cnt);
        end
        n_checks++;
        if (first_ws != 1) begin
            n_fail++;
            $display("FAIL first_rise: cycle %0d required 1", first_ws);
        end
        n_checks++;
        if (busy_bad != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_span: low_in_frame=%0d busy_at_done=%b required 0/0", busy_bad, busy);
        end
        n_checks++;
        if (low_run < 960) begin
            n_fail++;
            $display("FAIL tail_low: %0d low cycles required >=960", low_run);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b one cycle later required 0", done);
        end
    endtask

    task automatic test_start_handling();
        int cnt;
        kick();
        fork
            capture();
            begin
                repeat (100) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (2450) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        n_checks++;
        if (cap_timeout || latch_len != 960 || pix[0] !== 24'h008000) begin
            n_fail++;
            $display("FAIL start_ignored_frame: latch=%0d led0=%h required 960/008000", latch_len, pix[0]);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_not_queued: busy=%b required 0", busy);
        end
        kick();
        cnt = 0;
        while (done !== 1'b1 && cnt < 4000) begin
            @(negedge clk);
            cnt++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_start: busy=%b done=%b required 1/0", busy, done);
        end
        cnt = 0;
        while (done !== 1'b1 && cnt < 4000) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (cnt != 3481) begin
            n_fail++;
            $display("FAIL back_to_back_length: %0d cycles required 3481", cnt);
        end
    endtask

    task automatic test_buffer_writes();
        bright = 8'd255;
        write_pix(3'd7, 24'hFFFFFF);
        kick();
        fork
            capture();
            begin
                repeat (30) @(negedge clk);
                wr_en = 1'b1; wr_addr = 3'd6; wr_rgb = 24'h123456;
                @(negedge clk);
                wr_en = 1'b0;
            end
        join
        n_checks++;
        if (cap_timeout || pix[6] !== 24'h341256) begin
            n_fail++;
            $display("FAIL late_write_same_frame: led6=%h required 341256", pix[6]);
        end
        n_checks++;
        if (pix[0] !== 24'h008000 || pix[3] !== 24'h80FF40 || pix[1] !== 24'h0
            || pix[2] !== 24'h0 || pix[4] !== 24'h0 || pix[5] !== 24'h0) begin
            n_fail++;
            $display("FAIL addr7_ignored: led0..5=%h %h %h %h %h %h required 008000 0 0 80ff40 0 0",
                     pix[0], pix[1], pix[2], pix[3], pix[4], pix[5]);
        end
    endtask

    task automatic test_async_reset();
        int n;
        kick();
        n = 0;
        while (ws !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 20) begin
            n_fail++;
            $display("FAIL pre_reset_ws: ws=%b required 1 before reset", ws);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({ws, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset: ws/busy/done=%b required 000", {ws, busy, done});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        kick();
        capture();
        n_checks++;
        if (cap_timeout || shape_err != 0 || latch_len != 960) begin
            n_fail++;
            $display("FAIL post_reset_frame: timeout=%0d shape_err=%0d latch=%0d required 0/0/960",
                     cap_timeout, shape_err, latch_len);
        end
        for (int p = 0; p < 7; p++) begin
            n_checks++;
            if (pix[p] !== 24'h000000) begin
                n_fail++;
                $display("FAIL post_reset_zero: led%0d got %h required 000000", p, pix[p]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_brightness();
        test_frame_timing();
        test_start_handling();
        test_buffer_writes();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
